// File: rtl/apb_mem_slave_param.sv
// APB4 completer: flop word memory with byte strobes, WAIT_STATES extra access cycles, PSLVERR on bad address.
// Latency 2+WAIT_STATES cycles from setup. Outputs come from state only. Dropping PSEL aborts the transfer.
module apb_mem_slave_param #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0,
   parameter int ERRCNT_W    = 8
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   input  logic                    err_clr,
   output logic [ERRCNT_W-1:0]     err_cnt
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int AL = $clog2(NB);
   localparam int IW = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] AMASK   = ADDR_WIDTH'((64'd1 << AL) - 64'd1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
   localparam logic [3:0]            WS      = 4'(WAIT_STATES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  err_q;
   logic                  wr_q;
   logic [IW-1:0]         idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [NB-1:0]         strb_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [ERRCNT_W-1:0]   errcnt_q;
   logic [ERRCNT_W-1:0]   errcnt_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] idx_full;
   logic [IW-1:0]         dec_idx;
   logic                  dec_err;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  complete;
   logic                  commit_d;

   assign idx_full = PADDR >> AL;
   assign dec_idx  = idx_full[IW-1:0];
   assign dec_err  = ((PADDR & AMASK) != '0) || (idx_full >= DEPTH_A);
   assign rd_word  = dec_err ? '0 : mem_q[dec_idx];

   assign complete = (state_q == S_READY) && PSEL && PENABLE;
   assign commit_d = complete && wr_q && !err_q;

   always_comb begin
      errcnt_d = errcnt_q;
      if (err_clr)
         errcnt_d = '0;
      else if (complete && err_q && (errcnt_q != '1))
         errcnt_d = errcnt_q + 1'b1;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (PSEL && !PENABLE) begin
                  err_q   <= dec_err;
                  wr_q    <= PWRITE;
                  idx_q   <= dec_idx;
                  wdata_q <= PWDATA;
                  strb_q  <= PSTRB;
                  rdata_q <= PWRITE ? '0 : rd_word;
                  cnt_q   <= WS;
                  state_q <= (WS == 4'd0) ? S_READY : S_WAIT;
               end
            end
            S_WAIT: begin
               if (!PSEL)
                  state_q <= S_IDLE;
               else if (PENABLE) begin
                  if (cnt_q <= 4'd1)
                     state_q <= S_READY;
                  else
                     cnt_q <= cnt_q - 4'd1;
               end
            end
            S_READY: begin
               if (!PSEL || PENABLE)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (commit_d) begin
         for (int b = 0; b < NB; b++)
            if (strb_q[b])
               mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         errcnt_q <= '0;
      else
         errcnt_q <= errcnt_d;
   end

   assign PREADY  = (state_q == S_READY);
   assign PSLVERR = PREADY && err_q;
   assign PRDATA  = PREADY ? rdata_q : '0;
   assign err_cnt = errcnt_q;

endmodule

// File: tb/tb_apb_mem_slave_param.sv
// Directed bench: three completers (no wait, three waits, 2-bit error counter) on one shared APB bus.
module tb_apb_mem_slave_param;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic [2:0]  psel = '0;
   logic        PENABLE = 1'b0;
   logic        PWRITE = 1'b0;
   logic [31:0] PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [3:0]  PSTRB = '0;
   logic        err_clr = 1'b0;

   logic [31:0] prdata0, prdata1, prdata2;
   logic [2:0]  pready, pslverr;
   logic [7:0]  err_cnt0, err_cnt1;
   logic [1:0]  err_cnt2;

   int checks = 0;
   int errors = 0;

   always #5 PCLK = ~PCLK;

   apb_mem_slave_param #(.WAIT_STATES(0)) u0 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata0), .PREADY(pready[0]),
      .PSLVERR(pslverr[0]), .err_clr(err_clr), .err_cnt(err_cnt0));

   apb_mem_slave_param #(.WAIT_STATES(3)) u1 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata1), .PREADY(pready[1]),
      .PSLVERR(pslverr[1]), .err_clr(err_clr), .err_cnt(err_cnt1));

   apb_mem_slave_param #(.WAIT_STATES(0), .ERRCNT_W(2)) u2 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(prdata2), .PREADY(pready[2]),
      .PSLVERR(pslverr[2]), .err_clr(err_clr), .err_cnt(err_cnt2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sel_dat(input int inst);
      case (inst)
         0: return prdata0;
         1: return prdata1;
         default: return prdata2;
      endcase
   endfunction

   // One full transfer; cyc is the cycle (counting setup as 1) in which PREADY was seen.
   task automatic apb(input int inst, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err, output int cyc);
      @(negedge PCLK);
      psel = 3'b001 << inst; PENABLE = 1'b0;
      PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = strb;
      @(negedge PCLK);
      PENABLE = 1'b1;
      cyc = 2;
      while (!pready[inst] && cyc < 40) begin
         @(negedge PCLK);
         cyc++;
      end
      if (!pready[inst]) chk("ready_timeout", {63'b0, pready[inst]}, 64'd1);
      rd  = sel_dat(inst);
      err = pslverr[inst];
      @(negedge PCLK);
      psel = '0; PENABLE = 1'b0;
   endtask

   logic [31:0] rd;
   logic        err;
   int          cyc;

   initial begin
      repeat (3) @(negedge PCLK);
      chk("rst_pready", {61'b0, pready}, 64'd0);
      chk("rst_pslverr", {61'b0, pslverr}, 64'd0);
      chk("rst_prdata", prdata0, 64'd0);
      chk("rst_errcnt", err_cnt0, 64'd0);
      PRESET = 1'b0;

      for (int i = 0; i < 16; i++) begin
         apb(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd, err, cyc);
         chk("init_rdata", rd, 64'd0);
         chk("init_err", {63'b0, err}, 64'd0);
      end

      apb(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, rd, err, cyc);
      chk("wr8_cycles", 64'(cyc), 64'd2);
      chk("wr8_err", {63'b0, err}, 64'd0);
      chk("wr8_prdata", rd, 64'd0);
      apb(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, err, cyc);
      chk("rd8_cycles", 64'(cyc), 64'd2);
      chk("rd8_data", rd, 64'hDEADBEEF);

      apb(0, 1'b1, 32'h4, 32'hAAAAAAAA, 4'hF, rd, err, cyc);
      apb(0, 1'b1, 32'h4, 32'h11223344, 4'b0101, rd, err, cyc);
      apb(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, err, cyc);
      chk("strb_data", rd, 64'hAA22AA44);

      apb(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, err, cyc);
      chk("oor_err", {63'b0, err}, 64'd1);
      chk("oor_rdata", rd, 64'd0);
      apb(0, 1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, rd, err, cyc);
      chk("mis_err", {63'b0, err}, 64'd1);
      chk("errcnt_2", err_cnt0, 64'd2);
      apb(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, cyc);
      chk("mis_nowrite", rd, 64'd0);
      chk("good_noerr", {63'b0, err}, 64'd0);
      apb(0, 1'b1, 32'h8, 32'h01234567, 4'h0, rd, err, cyc);
      apb(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, err, cyc);
      chk("strb0_noop", rd, 64'hDEADBEEF);
      chk("errcnt_good", err_cnt0, 64'd2);

      err_clr = 1'b1;
      apb(0, 1'b0, 32'h44, 32'h0, 4'h0, rd, err, cyc);
      chk("clr_prio_err", {63'b0, err}, 64'd1);
      chk("clr_prio_cnt", err_cnt0, 64'd0);
      err_clr = 1'b0;
      apb(0, 1'b0, 32'h41, 32'h0, 4'h0, rd, err, cyc);
      chk("errcnt_after_clr", err_cnt0, 64'd1);

      apb(1, 1'b1, 32'hC, 32'h12345678, 4'hF, rd, err, cyc);
      chk("ws3_wr_cycles", 64'(cyc), 64'd5);
      @(negedge PCLK);
      psel = 3'b010; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'hC;
      @(negedge PCLK);
      PENABLE = 1'b1;
      chk("ws3_wait_prdata", prdata1, 64'd0);
      chk("ws3_wait_pready", {63'b0, pready[1]}, 64'd0);
      repeat (2) @(negedge PCLK);
      chk("ws3_c4_pready", {63'b0, pready[1]}, 64'd0);
      @(negedge PCLK);
      chk("ws3_c5_pready", {63'b0, pready[1]}, 64'd1);
      chk("ws3_c5_prdata", prdata1, 64'h12345678);
      @(negedge PCLK);
      psel = '0; PENABLE = 1'b0;

      @(negedge PCLK);
      psel = 3'b010; PWRITE = 1'b1; PADDR = 32'hC; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      chk("abort_pready", {63'b0, pready[1]}, 64'd0);
      psel = '0; PENABLE = 1'b0;
      @(negedge PCLK);
      psel = 3'b010; PWRITE = 1'b1; PADDR = 32'h40;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      psel = '0; PENABLE = 1'b0;
      @(negedge PCLK);
      chk("abort_errcnt", err_cnt1, 64'd0);
      apb(1, 1'b0, 32'hC, 32'h0, 4'h0, rd, err, cyc);
      chk("abort_nowrite", rd, 64'h12345678);
      chk("abort_idle_cycles", 64'(cyc), 64'd5);

      for (int i = 0; i < 5; i++) begin
         apb(2, 1'b0, 32'h40 + 32'(i), 32'h0, 4'h0, rd, err, cyc);
         if (i == 1) chk("sat_cnt_2", err_cnt2, 64'd2);
      end
      chk("sat_cnt_5", err_cnt2, 64'd3);

      apb(2, 1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, rd, err, cyc);
      @(negedge PCLK);
      psel = 3'b100; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0;
      @(negedge PCLK);
      PENABLE = 1'b1;
      chk("pre_rst_pready", {63'b0, pready[2]}, 64'd1);
      chk("pre_rst_prdata", prdata2, 64'h5A5A5A5A);
      #1 PRESET = 1'b1;
      #1;
      chk("mid_rst_pready", {63'b0, pready[2]}, 64'd0);
      chk("mid_rst_pslverr", {63'b0, pslverr[2]}, 64'd0);
      chk("mid_rst_prdata", prdata2, 64'd0);
      chk("mid_rst_errcnt", err_cnt2, 64'd0);
      psel = '0; PENABLE = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b0;
      apb(2, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, cyc);
      chk("post_rst_mem", rd, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
